// File: rtl/encoder_8to3.sv
// Debounced 8-to-3 priority encoder: synchronizes the request lines, waits for
// CNT_MAX+1 cycles of stability, then commits the highest set bit index.
module encoder_8to3 #(
  parameter logic [19:0] CNT_MAX = 20'd999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       out_valid,
  output logic       hit,
  output logic       multi_hot
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    STABLE = 2'd2
  } state_t;

  state_t      r_state;
  logic [19:0] r_cnt;
  logic [7:0]  r_sync1;
  logic [7:0]  r_in_s;
  logic [7:0]  r_in_d;
  logic [2:0]  r_out;
  logic        r_out_valid;
  logic        r_hit;
  logic        r_multi_hot;
  logic        w_change;

  function automatic logic [2:0] highest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  assign w_change = (r_in_s != r_in_d);

  // Synchronizer, stability counter and commit FSM.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1     <= 8'd0;
      r_in_s      <= 8'd0;
      r_in_d      <= 8'd0;
      r_state     <= IDLE;
      r_cnt       <= 20'd0;
      r_out       <= 3'd0;
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_multi_hot <= 1'b0;
    end else begin
      r_sync1     <= in;
      r_in_s      <= r_sync1;
      r_in_d      <= r_in_s;
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE, STABLE: begin
          if (w_change) begin
            r_state <= FILTER;
            r_cnt   <= 20'd0;
          end else begin
            r_state <= r_state;
          end
        end
        FILTER: begin
          if (w_change) begin
            r_cnt <= 20'd0;
          end else if (r_cnt == CNT_MAX - 20'd1) begin
            r_state <= STABLE;
            r_cnt   <= 20'd0;
            if (r_in_s != 8'd0) begin
              r_out       <= highest_index(r_in_s);
              r_hit       <= 1'b1;
              r_multi_hot <= more_than_one(r_in_s);
              r_out_valid <= 1'b1;
            end else begin
              // An all-zero commit clears the flags but keeps the last index.
              r_hit       <= 1'b0;
              r_multi_hot <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 20'd0;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign hit       = r_hit;
  assign multi_hot = r_multi_hot;

endmodule

// File: tb/tb_encoder_8to3.sv
// Scoreboard bench for encoder_8to3 with CNT_MAX = 3: commits are predicted when
// stimulus is applied and checked when out_valid fires.
module tb_encoder_8to3;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] in;
  logic [2:0] out;
  logic       out_valid;
  logic       hit;
  logic       multi_hot;

  int checks;
  int errors;
  logic [4:0] exp_q[$];
  logic prev_valid;

  encoder_8to3 #(.CNT_MAX(20'd3)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .hit       (hit),
    .multi_hot (multi_hot)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // out_valid is a single-cycle pulse; watch it on every falling edge.
  initial prev_valid = 1'b0;
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      checks++;
      if (prev_valid && out_valid) begin
        errors++;
        $display("FAIL pulse_width: out_valid high two cycles in a row");
      end
    end
    prev_valid = out_valid;
  end

  task automatic test_reset();
    sys_rst_n = 1'b0;
    in = 8'd0;
    repeat (3) step();
    checks++;
    if ({out, out_valid, hit, multi_hot} !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%0d v=%0b h=%0b m=%0b want all 0", out, out_valid, hit, multi_hot);
    end
    sys_rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if ({out, out_valid, hit, multi_hot} !== 6'd0) begin
      errors++;
      $display("FAIL reset_release: got out=%0d v=%0b h=%0b m=%0b want all 0", out, out_valid, hit, multi_hot);
    end
  endtask

  task automatic test_latency();
    logic [4:0] e;
    in = 8'b0000_0100;
    exp_q.push_back({3'd2, 1'b1, 1'b0});
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early: edge %0d out_valid=%0b want 0", k, out_valid);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge5: out_valid=%0b want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({out, hit, multi_hot} !== e) begin
        errors++;
        $display("FAIL latency_value: got %b want %b", {out, hit, multi_hot}, e);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_pulse_end: out_valid=%0b want 0", out_valid);
    end
  endtask

  // Drives one value, waits a bounded time for its commit, and checks it.
  task automatic test_commit(input logic [7:0] val, input logic [4:0] exp, input string name);
    logic got;
    logic [4:0] e;
    in = val;
    exp_q.push_back(exp);
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      void'(exp_q.pop_front());
      $display("FAIL %s_timeout: no out_valid within 30 cycles", name);
    end else begin
      e = exp_q.pop_front();
      if ({out, hit, multi_hot} !== e) begin
        errors++;
        $display("FAIL %s_value: got out=%0d h=%0b m=%0b want out=%0d h=%0b m=%0b",
                 name, out, hit, multi_hot, e[4:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_multi_hot();
    int pulses;
    test_commit(8'b1001_0000, {3'd7, 1'b1, 1'b1}, "multi_hot");
    pulses = 0;
    repeat (10) begin
      step();
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL no_recommit: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_zero_commit();
    int pulses;
    test_commit(8'b0010_0000, {3'd5, 1'b1, 1'b0}, "commit5");
    in = 8'd0;
    pulses = 0;
    repeat (10) begin
      step();
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || {out, hit, multi_hot} !== {3'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL zero_commit: pulses=%0d out=%0d h=%0b m=%0b want 0,5,0,0", pulses, out, hit, multi_hot);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    in = 8'b0010_0000;
    repeat (2) step();
    in = 8'd0;
    repeat (12) begin
      step();
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || {out, hit, multi_hot} !== {3'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL glitch: pulses=%0d out=%0d h=%0b m=%0b want 0,5,0,0", pulses, out, hit, multi_hot);
    end
  endtask

  task automatic test_reset_in_filter();
    logic [4:0] e;
    test_commit(8'b1000_0000, {3'd7, 1'b1, 1'b0}, "pre_reset");
    in = 8'b0000_0001;
    repeat (3) step();
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({out, out_valid, hit, multi_hot} !== 6'd0) begin
      errors++;
      $display("FAIL async_reset: got out=%0d v=%0b h=%0b m=%0b want all 0", out, out_valid, hit, multi_hot);
    end
    repeat (2) step();
    sys_rst_n = 1'b1;
    exp_q.push_back({3'd0, 1'b1, 1'b0});
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || hit !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_early: edge %0d v=%0b h=%0b want 0,0", k, out_valid, hit);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_commit: out_valid=%0b want 1", out_valid);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if ({out, hit, multi_hot} !== e) begin
        errors++;
        $display("FAIL post_reset_value: got %b want %b", {out, hit, multi_hot}, e);
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] onehot;
    logic [7:0] dec;
    in = 8'd0;
    repeat (10) step();
    for (int k = 0; k < 8; k++) begin
      onehot = 8'b0000_0001 << k;
      test_commit(onehot, {3'(k), 1'b1, 1'b0}, "loopback");
      dec = 8'b0000_0001 << out;
      checks++;
      if (dec !== onehot) begin
        errors++;
        $display("FAIL loopback_decode: k=%0d got %b want %b", k, dec, onehot);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sys_rst_n = 1'b0;
    in = 8'd0;
    test_reset();
    test_latency();
    test_multi_hot();
    test_zero_commit();
    test_glitch();
    test_reset_in_filter();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
